// File: rtl/bldc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bldc_pkg
//  Description : Shared types and helpers for the six-step BLDC commutator.
//                Holds the controller state encoding, the sector and leg
//                constants, the hall-code decoder and the commutation table.
//                Gate vectors are ordered {C,B,A}, so leg A is bit 0.
//  Revision    : 1.0  initial release
// ============================================================================
package bldc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEADTIME = 2'd1,
    ST_DRIVE    = 2'd2
  } state_e;

  localparam logic [2:0] C_SECTOR_A = 3'd0;
  localparam logic [2:0] C_SECTOR_B = 3'd1;
  localparam logic [2:0] C_SECTOR_C = 3'd2;
  localparam logic [2:0] C_SECTOR_D = 3'd3;
  localparam logic [2:0] C_SECTOR_E = 3'd4;
  localparam logic [2:0] C_SECTOR_F = 3'd5;

  localparam logic [2:0] C_LEG_NONE = 3'b000;
  localparam logic [2:0] C_LEG_A    = 3'b001;
  localparam logic [2:0] C_LEG_B    = 3'b010;
  localparam logic [2:0] C_LEG_C    = 3'b100;

  typedef struct packed {
    logic       valid;
    logic [2:0] sector;
  } hall_dec_t;

  // Hall code {h1,h2,h3} to sector. 000 and 111 are reported invalid.
  function automatic hall_dec_t hall_to_sector(input logic [2:0] hall);
    hall_dec_t r;
    r.valid  = 1'b1;
    r.sector = C_SECTOR_A;
    case (hall)
      3'b101:  r.sector = C_SECTOR_A;
      3'b100:  r.sector = C_SECTOR_B;
      3'b110:  r.sector = C_SECTOR_C;
      3'b010:  r.sector = C_SECTOR_D;
      3'b011:  r.sector = C_SECTOR_E;
      3'b001:  r.sector = C_SECTOR_F;
      default: r.valid  = 1'b0;
    endcase
    return r;
  endfunction

  // Returns {gate_h, gate_l}. Exactly one high leg and one different low leg
  // for every legal sector; all-off for anything else.
  function automatic logic [5:0] gate_table(input logic [2:0] sector, input logic dir);
    logic [2:0] h;
    logic [2:0] l;
    h = C_LEG_NONE;
    l = C_LEG_NONE;
    if (dir) begin
      case (sector)
        C_SECTOR_A: begin h = C_LEG_A; l = C_LEG_B; end
        C_SECTOR_B: begin h = C_LEG_A; l = C_LEG_C; end
        C_SECTOR_C: begin h = C_LEG_B; l = C_LEG_C; end
        C_SECTOR_D: begin h = C_LEG_B; l = C_LEG_A; end
        C_SECTOR_E: begin h = C_LEG_C; l = C_LEG_A; end
        C_SECTOR_F: begin h = C_LEG_C; l = C_LEG_B; end
        default:    begin h = C_LEG_NONE; l = C_LEG_NONE; end
      endcase
    end else begin
      case (sector)
        C_SECTOR_A: begin h = C_LEG_B; l = C_LEG_A; end
        C_SECTOR_B: begin h = C_LEG_C; l = C_LEG_A; end
        C_SECTOR_C: begin h = C_LEG_C; l = C_LEG_B; end
        C_SECTOR_D: begin h = C_LEG_A; l = C_LEG_B; end
        C_SECTOR_E: begin h = C_LEG_A; l = C_LEG_C; end
        C_SECTOR_F: begin h = C_LEG_B; l = C_LEG_C; end
        default:    begin h = C_LEG_NONE; l = C_LEG_NONE; end
      endcase
    end
    return {h, l};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bldc_commutator.sv
`default_nettype none
// ============================================================================
//  Module      : bldc_commutator
//  Description : Six-step BLDC commutation stage. Decodes debounced hall
//                codes into sectors, drives one high-side and one low-side
//                gate from the dir-selected table, inserts an all-off dead
//                time on every sector/direction change and on start-up, and
//                forces all gates off on disable, fault or invalid hall code.
//                High-side gates are chopped by pwm_in combinationally.
//  Ports       : CLK, reset_n (async, active-low)
//                enable, dir, hall[2:0], fault_n, pwm_in   -- inputs
//                inh[2:0], inl[2:0] {C,B,A}, sector[2:0],
//                hall_error, stall                         -- outputs
//  Config      : define BLDC_STALL_DETECT_EN to enable the stall detector
//                (STALL_CYCLES without a sector change -> sticky stall).
//  Revision    : 1.0  initial release
// ============================================================================
module bldc_commutator
  import bldc_pkg::*;
#(
  parameter int unsigned DEAD_TIME    = 32,          // 1..255
  parameter int unsigned STALL_CYCLES = 16_000_000
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       dir,
  input  logic [2:0] hall,
  input  logic       fault_n,
  input  logic       pwm_in,
  output logic [2:0] inh,
  output logic [2:0] inl,
  output logic [2:0] sector,
  output logic       hall_error,
  output logic       stall
);

  localparam logic [7:0] C_DT_LOAD = 8'(DEAD_TIME - 1);

  state_e     state_q, state_d;
  logic [2:0] sector_q, sector_d;
  logic       dir_q, dir_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] gate_h_q, gate_h_d;
  logic [2:0] gate_l_q, gate_l_d;
  logic       hall_err_q;

  hall_dec_t  dec;
  logic       change_evt;
  logic       force_idle;
  logic       start_ok;
  logic       stall_flag;
  logic       stall_hit;

  assign dec        = hall_to_sector(hall);
  assign change_evt = dec.valid && ((dec.sector != sector_q) || (dir != dir_q));
  assign force_idle = !enable || !fault_n || !dec.valid || stall_hit;
  assign start_ok   = enable && fault_n && dec.valid && !stall_flag;

`ifdef BLDC_STALL_DETECT_EN
  localparam logic [23:0] C_STALL_LAST = 24'(STALL_CYCLES - 1);

  logic [23:0] stall_cnt_q, stall_cnt_d;
  logic        stall_q, stall_d;

  // Only a running controller can stall; the count restarts on any change.
  assign stall_hit = (state_q != ST_IDLE) && (stall_cnt_q == C_STALL_LAST);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    stall_d     = stall_q;
    if ((state_q == ST_IDLE) || change_evt) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 24'd1;
    end
    // Sticky until the run request is withdrawn.
    if (!enable) begin
      stall_d = 1'b0;
    end else if (stall_hit) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign stall_flag = stall_q;
`else
  assign stall_hit  = 1'b0;
  assign stall_flag = 1'b0;
`endif

  // Next-state logic. Priority: forced IDLE > change event > dead-time count.
  always_comb begin
    state_d  = state_q;
    sector_d = sector_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    gate_h_d = gate_h_q;
    gate_l_d = gate_l_q;

    case (state_q)
      ST_IDLE: begin
        gate_h_d = '0;
        gate_l_d = '0;
        cnt_d    = '0;
        if (start_ok) begin
          sector_d = dec.sector;
          dir_d    = dir;
          cnt_d    = C_DT_LOAD;
          state_d  = ST_DEADTIME;
        end
      end

      ST_DEADTIME, ST_DRIVE: begin
        if (force_idle) begin
          state_d  = ST_IDLE;
          gate_h_d = '0;
          gate_l_d = '0;
          cnt_d    = '0;
        end else if (change_evt) begin
          // Also restarts a dead time already in progress.
          sector_d = dec.sector;
          dir_d    = dir;
          gate_h_d = '0;
          gate_l_d = '0;
          cnt_d    = C_DT_LOAD;
          state_d  = ST_DEADTIME;
        end else if (state_q == ST_DEADTIME) begin
          if (cnt_q == 8'd0) begin
            state_d              = ST_DRIVE;
            {gate_h_d, gate_l_d} = gate_table(sector_q, dir_q);
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        gate_h_d = '0;
        gate_l_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      sector_q   <= '0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      gate_h_q   <= '0;
      gate_l_q   <= '0;
      hall_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sector_q   <= sector_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      gate_h_q   <= gate_h_d;
      gate_l_q   <= gate_l_d;
      hall_err_q <= !dec.valid;
    end
  end

  assign inh        = gate_h_q & {3{pwm_in}};
  assign inl        = gate_l_q;
  assign sector     = sector_q;
  assign hall_error = hall_err_q;
  assign stall      = stall_flag;

endmodule
`default_nettype wire

// File: doc/bldc_commutator.md
# bldc_commutator

Six-step BLDC commutation stage between the 3-bit hall debouncer and the half-bridge gate pins. Decodes debounced hall codes into sector 0–5 and drives one high-side and one low-side gate from a fixed table selected by `dir`. Enforces an all-off dead time on every sector or direction change, and forces all gates off on disable, driver fault or an invalid hall code. The high-side gates are chopped by the PWM block output.

## Interface
- `DEAD_TIME`, 32, all-off cycles after any sector/direction change or leaving IDLE; legal range 1..255
- `STALL_CYCLES`, 16_000_000, cycles without a sector change before a stall is declared; used only with `BLDC_STALL_DETECT_EN`
- `CLK` input 1: 16 MHz system clock; single clock domain
- `reset_n` input 1: asynchronous, active-low reset
- `enable` input 1: run request; 0 forces IDLE
- `dir` input 1: 1 = forward table, 0 = reverse table
- `hall` input 3: debounced `{h1,h2,h3}`
- `fault_n` input 1: driver fault, active-low; 0 forces IDLE
- `pwm_in` input 1: PWM from the pwm block
- `inh` output 3: high-side gates `{C,B,A}` = `gate_h & {3{pwm_in}}`
- `inl` output 3: low-side gates `{C,B,A}` = `gate_l`
- `sector` output 3: current sector, 0..5
- `hall_error` output 1: registered, 1 while the sampled hall code is 000 or 111
- `stall` output 1: sticky stall flag

## Operation
- **Hall decode:** 101→0, 100→1, 110→2, 010→3, 011→4, 001→5. Codes 000 and 111 are invalid.
- **Forward table (`dir`=1), high/low leg:** 0:A/B, 1:A/C, 2:B/C, 3:B/A, 4:C/A, 5:C/B.
- **Reverse table (`dir`=0), high/low leg:** 0:B/A, 1:C/A, 2:C/B, 3:A/B, 4:A/C, 5:B/C.
- **States:** IDLE, DEADTIME, DRIVE.
- **IDLE:**
  - `gate_h` = `gate_l` = 0.
  - Leaves when `enable` & `fault_n` & valid hall & !`stall`.
  - On leaving: loads `sector_q`/`dir_q`, sets `cnt` = DEAD_TIME−1, goes to DEADTIME.
- **DEADTIME:**
  - Gates stay 0.
  - When `cnt` = 0, goes to DRIVE and gates get `table(sector_q, dir_q)`; otherwise `cnt` decrements.
- **DRIVE:** holds the table pattern.
- **Change event (DEADTIME or DRIVE):** a valid decoded sector ≠ `sector_q`, or `dir` ≠ `dir_q`.
  - Updates `sector_q`/`dir_q`, gates go 0, `cnt` = DEAD_TIME−1, state goes to DEADTIME.
  - A change inside DEADTIME restarts the count.
- **Forced IDLE from any state**, gates 0 on the next edge, on any of:
  - `enable`=0
  - `fault_n`=0
  - invalid hall
  - `stall` rising
- **Priority:** forced IDLE > change event > count.
- **Invariant:** in every cycle, at most one `gate_h` bit and at most one `gate_l` bit is set, and never both on the same leg.

## Timing
- **Reset:** asynchronous, all registers cleared.
  - State IDLE, `gate_h` = `gate_l` = 0, `inh` = `inl` = 0.
  - `sector` = 0, `hall_error` = 0, `stall` = 0, `cnt` = 0.
- **Inputs:** `hall`, `dir`, `enable` and `fault_n` are sampled on the CLK rising edge; no extra synchronizer (the debouncer output is synchronous).
- **Change-event timing:** for a change event sampled at edge k, gates are 0 from edge k through edge k+DEAD_TIME−1. The new pattern appears after edge k+DEAD_TIME, so the all-off time is exactly DEAD_TIME cycles.
- **Forced-IDLE latency:** 1 cycle to gates off.
- **`pwm_in` path:** combinational AND into `inh`, zero added latency.
- **`sector` output:** reflects `sector_q`, updated at the change edge.
- **Reset mid-operation:** gates drop asynchronously. After release, a fresh DEADTIME always precedes DRIVE.

## Configuration
- **With `BLDC_STALL_DETECT_EN` defined:**
  - A 24-bit counter clears on every change event and in IDLE; otherwise it increments, saturating.
  - When the counter reaches STALL_CYCLES−1 in DEADTIME/DRIVE, `stall` is set and the state goes to IDLE.
  - `stall` clears only when `enable`=0 or on reset.
- **Without it:** `stall` is tied to 0, there is no counter, and STALL_CYCLES is ignored.

## Structure
- Shared package `bldc_pkg` holds:
  - state enum (IDLE/DEADTIME/DRIVE)
  - sector constants A..F = 0..5
  - function `hall_to_sector` returning a valid bit plus the sector
  - function `gate_table(sector, dir)` returning `{gate_h, gate_l}`
- No sub-module; the dead-time counter and the stall counter stay inline.

## Test plan
- **Reset / startup:** `reset_n`=0 → all outputs 0. Release with `enable`=1, `fault_n`=1, `hall`=101, `dir`=1, `pwm_in`=1 → gates 0 for 32 cycles, then `inh`=001, `inl`=010.
- **Forward sequence:** step `hall` 101→100→110→010→011→001, 200 cycles apart → `sector` 0..5, each step preceded by exactly 32 all-off cycles, with the forward table patterns.
- **Direction flip:** in DRIVE at sector 2, toggle `dir` to 0 → 32 off cycles, then `inh`=100, `inl`=010. A hall change 10 cycles into the dead time restarts the full 32-cycle count.
- **Faults:** `fault_n`=0 or `hall`=111 in DRIVE → gates 0 on the next edge; `hall_error`=1 only for 111. After recovery → 32-cycle dead time before DRIVE.
- **PWM gating:** toggle `pwm_in` in DRIVE → `inh` follows `pwm_in` combinationally, `inl` stays constant. Check the one-high/one-low invariant every cycle.
- **Stall (`BLDC_STALL_DETECT_EN`, STALL_CYCLES=1000):** hold `hall` constant → `stall`=1 and gates off at 1000 cycles. `enable`=0 then 1 → `stall` clears and the dead time restarts.
